i2s_adc_rx: RTL and testbench

- Upstream neighbour of the audio-sync PIO input.
- Deserialises the codec's I2S ADC stream (BCLK, ADCLRCK, ADCDAT), all asynchronous to clk, into one left/right sample pair per frame.
- Exposes the pair on an Avalon-MM slave.
- Drives sync_out, a stretched pulse on every completed pair; sync_out connects to the PIO in_port, whose rising-edge capture raises the Nios IRQ.

---
 rtl/i2s_rx_pkg.sv | 22 ++
 rtl/sync_edge.sv | 32 +++
 rtl/i2s_adc_rx.sv | 192 +++++++++++++++++++
 tb/tb_i2s_adc_rx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/i2s_rx_pkg.sv
// Shared types and constants for the I2S ADC receiver: FSM states, slave
// register map and status bit positions.
package i2s_rx_pkg;

    typedef enum logic [1:0] {
        ALIGN = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } rx_state_e;

    localparam logic CH_L = 1'b0;
    localparam logic CH_R = 1'b1;

    localparam logic [1:0] ADDR_LEFT   = 2'd0;
    localparam logic [1:0] ADDR_RIGHT  = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    localparam int STAT_VALID = 0;
    localparam int STAT_OVR   = 1;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for one asynchronous pin, plus a delay flop that
// turns the synchronised level into single-cycle rise/fall strobes.
module sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~dly_q;
    assign fall_o  = ~sync_q & dly_q;

endmodule

// File: rtl/i2s_adc_rx.sv
// I2S ADC deserialiser: captures one left/right pair per frame, exposes it on
// an Avalon-MM read slave and pulses sync_out for the PIO on every pair.
module i2s_adc_rx
    import i2s_rx_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int SYNC_HOLD = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        aud_bclk,
    input  logic        aud_adclrck,
    input  logic        aud_adcdat,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        sync_out
);

    localparam int BW = $clog2(DATA_W);
    localparam int CW = $clog2(SYNC_HOLD + 1);

    logic bclk_lvl, bclk_rise, bclk_fall;
    logic lr_lvl, lr_rise, lr_fall;
    logic dat_lvl, dat_rise, dat_fall;

    sync_edge u_sync_bclk (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (aud_bclk),
        .level_o (bclk_lvl),
        .rise_o  (bclk_rise),
        .fall_o  (bclk_fall)
    );

    sync_edge u_sync_lrck (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (aud_adclrck),
        .level_o (lr_lvl),
        .rise_o  (lr_rise),
        .fall_o  (lr_fall)
    );

    // Data goes through the same synchroniser depth as BCLK so the bit seen
    // on bclk_rise is the one the codec presented with that edge.
    sync_edge u_sync_dat (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (aud_adcdat),
        .level_o (dat_lvl),
        .rise_o  (dat_rise),
        .fall_o  (dat_fall)
    );

    logic unused_sync_bits;
    assign unused_sync_bits = ^{bclk_lvl, bclk_fall, lr_lvl, dat_rise, dat_fall};

    rx_state_e          state_q;
    logic               ch_q;
    logic [BW-1:0]      bitcnt_q;
    logic [DATA_W-1:0]  shift_q;
    logic [DATA_W-1:0]  shift_d;
    logic [DATA_W-1:0]  lshadow_q;
    logic               lr_edge;
    logic               last_bit;
    logic               commit_d;

    assign lr_edge  = lr_rise | lr_fall;
    assign last_bit = (bitcnt_q == BW'(DATA_W - 1));
    assign shift_d  = {shift_q[DATA_W-2:0], dat_lvl};

    // An LRCK edge outranks a coincident BCLK edge, so a truncated right
    // channel can never reach the commit below.
    assign commit_d = (state_q == SHIFT) && !lr_edge && bclk_rise &&
                      last_bit && (ch_q == CH_R);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ALIGN;
            ch_q      <= CH_L;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            lshadow_q <= '0;
        end else if (state_q != ALIGN && lr_edge) begin
            state_q <= SKIP;
            ch_q    <= lr_rise ? CH_R : CH_L;
        end else begin
            case (state_q)
                ALIGN: begin
                    if (lr_fall) begin
                        state_q <= SKIP;
                        ch_q    <= CH_L;
                    end
                end
                SKIP: begin
                    if (bclk_rise) begin
                        state_q  <= SHIFT;
                        bitcnt_q <= '0;
                    end
                end
                SHIFT: begin
                    if (bclk_rise) begin
                        shift_q  <= shift_d;
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (last_bit) begin
                            state_q <= DONE;
                            if (ch_q == CH_L) begin
                                lshadow_q <= shift_d;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= ALIGN;
                end
            endcase
        end
    end

    // Avalon read slave: no wait states, no valid/ready pair. readdata is
    // re-registered from the address mux every cycle (latency 1, no hold);
    // chipselect & read only qualify the side-effect clears.
    logic               rd_en;
    logic [DATA_W-1:0]  left_q;
    logic [DATA_W-1:0]  right_q;
    logic               valid_q;
    logic               ovr_q;
    logic [CW-1:0]      sync_cnt_q;
    logic               sync_out_q;
    logic [31:0]        readdata_q;
    logic [31:0]        readdata_d;
    logic [31:0]        status_d;

    assign rd_en = chipselect & read;

    always_comb begin
        status_d             = '0;
        status_d[STAT_VALID] = valid_q;
        status_d[STAT_OVR]   = ovr_q;
        readdata_d           = '0;
        case (address)
            ADDR_LEFT:   readdata_d = 32'(signed'(left_q));
            ADDR_RIGHT:  readdata_d = 32'(signed'(right_q));
            ADDR_STATUS: readdata_d = status_d;
            default:     readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            left_q     <= '0;
            right_q    <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
            sync_cnt_q <= '0;
            sync_out_q <= 1'b0;
            readdata_q <= '0;
        end else begin
            readdata_q <= readdata_d;
            sync_out_q <= (sync_cnt_q != '0);

            if (commit_d) begin
                left_q     <= lshadow_q;
                right_q    <= shift_d;
                sync_cnt_q <= CW'(SYNC_HOLD);
            end else if (sync_cnt_q != '0) begin
                sync_cnt_q <= sync_cnt_q - 1'b1;
            end

            if (commit_d) begin
                valid_q <= 1'b1;
            end else if (rd_en && address == ADDR_RIGHT) begin
                valid_q <= 1'b0;
            end

            if (commit_d && valid_q) begin
                ovr_q <= 1'b1;
            end else if (rd_en && address == ADDR_STATUS) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign readdata = readdata_q;
    assign sync_out = sync_out_q;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Directed bench for i2s_adc_rx: drives I2S frames at BCLK = clk/16 into a
// 24-bit and a 16-bit instance and checks reads and sync_out pulses.
module tb_i2s_adc_rx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        aud_bclk;
    logic        aud_adclrck;
    logic        aud_adcdat;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic [31:0] readdata;
    logic        sync_out;
    logic [31:0] readdata16;
    logic        sync_out16;

    int          checks = 0;
    int          errors = 0;
    int          hi_cnt = 0;
    int          rise_cnt = 0;
    logic        sync_prev = 1'b0;
    logic [31:0] probe_val;

    always #5 clk = ~clk;

    i2s_adc_rx #(.DATA_W(24), .SYNC_HOLD(4)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .aud_bclk    (aud_bclk),
        .aud_adclrck (aud_adclrck),
        .aud_adcdat  (aud_adcdat),
        .address     (address),
        .chipselect  (chipselect),
        .read        (read),
        .readdata    (readdata),
        .sync_out    (sync_out)
    );

    i2s_adc_rx #(.DATA_W(16), .SYNC_HOLD(4)) u_dut16 (
        .clk         (clk),
        .reset_n     (reset_n),
        .aud_bclk    (aud_bclk),
        .aud_adclrck (aud_adclrck),
        .aud_adcdat  (aud_adcdat),
        .address     (address),
        .chipselect  (chipselect),
        .read        (read),
        .readdata    (readdata16),
        .sync_out    (sync_out16)
    );

    always @(negedge clk) begin
        if (sync_out) hi_cnt <= hi_cnt + 1;
        if (sync_out && !sync_prev) rise_cnt <= rise_cnt + 1;
        sync_prev <= sync_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d, output logic [31:0] d16);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        read       = 1'b1;
        @(negedge clk);
        d          = readdata;
        d16        = readdata16;
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    // One BCLK period: 8 clk low, 8 clk high; LRCK/DATA change on the fall.
    // With probe set, address 1 is read in the clk where the commit of this
    // bit lands (3rd posedge after the BCLK rise reaches the pin).
    task automatic slot(input logic lr, input logic b, input bit probe);
        @(negedge clk);
        aud_bclk    = 1'b0;
        aud_adclrck = lr;
        aud_adcdat  = b;
        repeat (8) @(negedge clk);
        aud_bclk = 1'b1;
        if (probe) begin
            repeat (2) @(negedge clk);
            address    = 2'd1;
            chipselect = 1'b1;
            read       = 1'b1;
            @(negedge clk);
            probe_val  = readdata;
            chipselect = 1'b0;
            read       = 1'b0;
            repeat (4) @(negedge clk);
        end else begin
            repeat (7) @(negedge clk);
        end
    endtask

    // Word is MSB-aligned in 32 bits; slot 0 is the I2S delay bit.
    task automatic channel(input logic lr, input logic [31:0] w, input int first,
                           input int last, input int probe_slot);
        for (int s = first; s <= last; s++) begin
            logic b;
            b = (s == 0) ? 1'b0 : w[32-s];
            slot(lr, b, s == probe_slot);
        end
    endtask

    task automatic frame(input logic [31:0] l, input logic [31:0] r, input int probe_slot);
        channel(1'b0, l, 0, 31, -1);
        channel(1'b1, r, 0, 31, probe_slot);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] d16;

        reset_n     = 1'b0;
        aud_bclk    = 1'b0;
        aud_adclrck = 1'b0;
        aud_adcdat  = 1'b0;
        address     = 2'd0;
        chipselect  = 1'b0;
        read        = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_readdata", readdata, 32'h0);
        check("reset_sync_out", {31'b0, sync_out}, 32'h0);
        check("reset_readdata16", readdata16, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        rd(2'd2, d, d16); check("reset_status", d, 32'h0);
        rd(2'd0, d, d16); check("reset_left", d, 32'h0);
        rd(2'd1, d, d16); check("reset_right", d, 32'h0);

        // Right channel before any LRCK fall must be ignored.
        channel(1'b1, 32'hFEDCBA5A, 0, 31, -1);
        check("align_no_pulse", rise_cnt, 0);
        rd(2'd2, d, d16); check("align_status", d, 32'h0);

        frame(32'h123456A5, 32'hFEDCBA3C, -1);
        check("f1_rises", rise_cnt, 1);
        check("f1_hi_cycles", hi_cnt, 4);
        rd(2'd2, d, d16); check("f1_status", d, 32'h1);
        rd(2'd0, d, d16); check("f1_left", d, 32'h00123456);
        rd(2'd1, d, d16); check("f1_right", d, 32'hFFFEDCBA);
        rd(2'd2, d, d16); check("f1_status_clr", d, 32'h0);

        frame(32'h123456A5, 32'hFEDCBA3C, -1);
        frame(32'h123456A5, 32'hFEDCBA3C, -1);
        check("f3_rises", rise_cnt, 3);
        check("f3_hi_cycles", hi_cnt, 12);
        rd(2'd2, d, d16); check("ovr_status", d, 32'h3);
        rd(2'd2, d, d16); check("ovr_cleared", d, 32'h1);
        rd(2'd1, d, d16); check("f3_right", d, 32'hFFFEDCBA);
        rd(2'd2, d, d16); check("valid_cleared", d, 32'h0);
        rd(2'd3, d, d16); check("reserved", d, 32'h0);

        // Right channel cut short after 10 bits by the next LRCK fall.
        channel(1'b0, 32'h0A0B0CFF, 0, 31, -1);
        channel(1'b1, 32'h11111111, 0, 10, -1);
        check("trunc_no_pulse", rise_cnt, 3);
        rd(2'd2, d, d16); check("trunc_status", d, 32'h0);
        frame(32'h123ABC00, 32'h65432100, -1);
        check("after_trunc_rises", rise_cnt, 4);
        check("after_trunc_hi", hi_cnt, 16);
        rd(2'd2, d, d16); check("after_trunc_status", d, 32'h1);
        rd(2'd0, d, d16); check("after_trunc_left", d, 32'h00123ABC);
        rd(2'd1, d, d16); check("after_trunc_right", d, 32'h00654321);

        // Reset in the middle of the right channel's shift.
        channel(1'b0, 32'h77777700, 0, 31, -1);
        channel(1'b1, 32'h55555500, 0, 12, -1);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_readdata", readdata, 32'h0);
        check("midrst_sync_out", {31'b0, sync_out}, 32'h0);
        check("midrst_readdata16", readdata16, 32'h0);
        reset_n = 1'b1;
        rd(2'd2, d, d16); check("midrst_status", d, 32'h0);
        rd(2'd1, d, d16); check("midrst_right", d, 32'h0);
        channel(1'b1, 32'h55555500, 13, 31, -1);
        check("midrst_no_pulse", rise_cnt, 4);
        rd(2'd2, d, d16); check("midrst_status2", d, 32'h0);
        frame(32'h0F0F0F00, 32'h00F0F000, -1);
        check("midrst_rises", rise_cnt, 5);
        rd(2'd2, d, d16); check("midrst_status3", d, 32'h1);
        rd(2'd0, d, d16); check("midrst_left", d, 32'h000F0F0F);

        // Read of address 1 in the commit clk: old data, valid set wins.
        frame(32'h00000100, 32'h7FFFFF00, 24);
        check("probe_old_right", probe_val, 32'h0000F0F0);
        rd(2'd2, d, d16); check("probe_status", d, 32'h3);
        rd(2'd1, d, d16); check("probe_new_right", d, 32'h007FFFFF);
        check("probe_rises", rise_cnt, 6);

        // 16-bit instance: trailing ones after bit 16 must be ignored.
        frame(32'h8000FFFF, 32'h0001FFFF, -1);
        rd(2'd0, d, d16);
        check("w16_left", d16, 32'hFFFF8000);
        check("w24_left", d, 32'hFF8000FF);
        rd(2'd1, d, d16);
        check("w16_right", d16, 32'h00000001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
